counter_step_decoder: RTL and testbench

Receive-side companion to the lab's 4-bit up/down counter with load. It samples the counter's 4-bit output and classifies every transition as an up step (+3), a down step (−5) or a parallel load. It keeps saturating per-class event counts and a same-direction run length, so a bench or display block can tell what the counter did from its output alone.

---
 rtl/counter_step_decoder.sv | 137 +++++++++++++
 tb/tb_counter_step_decoder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/counter_step_decoder.sv
// Decodes the observed output of a 4-bit +3/-5/load counter into step classes.
// Keeps saturating per-class event counts and a same-direction run length.
module counter_step_decoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             sample_valid,
  input  logic [3:0]       sample,
  input  logic             resync,
  output logic             dec_valid,
  output logic             is_up,
  output logic             is_down,
  output logic             is_load,
  output logic [3:0]       load_value,
  output logic [CNT_W-1:0] up_cnt,
  output logic [CNT_W-1:0] down_cnt,
  output logic [CNT_W-1:0] load_cnt,
  output logic [3:0]       run_len,
  output logic             dir_change,
  output logic             fsm_state
);

  // Handshake: a sample is consumed on every rising edge where sample_valid=1;
  // dec_valid is a one-cycle pulse with no backpressure.
  typedef enum logic {IDLE = 1'b0, TRACK = 1'b1} state_t;
  typedef enum logic [1:0] {DIR_NONE = 2'd0, DIR_UP = 2'd1, DIR_DOWN = 2'd2} dir_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state, state_n;
  dir_t             last_dir, last_dir_n;
  logic [3:0]       ref_val, ref_n;
  logic [3:0]       diff;
  logic             dec_valid_n, is_up_n, is_down_n, is_load_n, dir_change_n;
  logic [3:0]       load_value_n, run_len_n;
  logic [CNT_W-1:0] up_cnt_n, down_cnt_n, load_cnt_n;

  assign fsm_state = state;
  assign diff      = sample - ref_val;

  always_comb begin
    state_n      = state;
    ref_n        = ref_val;
    last_dir_n   = last_dir;
    dec_valid_n  = 1'b0;
    is_up_n      = 1'b0;
    is_down_n    = 1'b0;
    is_load_n    = 1'b0;
    dir_change_n = 1'b0;
    load_value_n = load_value;
    up_cnt_n     = up_cnt;
    down_cnt_n   = down_cnt;
    load_cnt_n   = load_cnt;
    run_len_n    = run_len;

    if (resync) begin
      // Re-acquire only; statistics survive a resync.
      if (sample_valid) begin
        ref_n   = sample;
        state_n = TRACK;
      end else begin
        state_n = IDLE;
      end
    end else if (sample_valid) begin
      ref_n = sample;
      case (state)
        IDLE: state_n = TRACK;
        TRACK: begin
          dec_valid_n = 1'b1;
          if (diff == 4'd3) begin
            is_up_n = 1'b1;
            if (up_cnt != CNT_MAX) up_cnt_n = up_cnt + CNT_ONE;
            if (last_dir == DIR_UP) begin
              if (run_len != 4'd15) run_len_n = run_len + 4'd1;
            end else begin
              run_len_n    = 4'd1;
              last_dir_n   = DIR_UP;
              dir_change_n = (last_dir == DIR_DOWN);
            end
          end else if (diff == 4'd11) begin
            is_down_n = 1'b1;
            if (down_cnt != CNT_MAX) down_cnt_n = down_cnt + CNT_ONE;
            if (last_dir == DIR_DOWN) begin
              if (run_len != 4'd15) run_len_n = run_len + 4'd1;
            end else begin
              run_len_n    = 4'd1;
              last_dir_n   = DIR_DOWN;
              dir_change_n = (last_dir == DIR_UP);
            end
          end else begin
            is_load_n    = 1'b1;
            load_value_n = sample;
            if (load_cnt != CNT_MAX) load_cnt_n = load_cnt + CNT_ONE;
            run_len_n    = 4'd0;
            last_dir_n   = DIR_NONE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state      <= IDLE;
      ref_val    <= 4'd0;
      last_dir   <= DIR_NONE;
      dec_valid  <= 1'b0;
      is_up      <= 1'b0;
      is_down    <= 1'b0;
      is_load    <= 1'b0;
      dir_change <= 1'b0;
      load_value <= 4'd0;
      up_cnt     <= '0;
      down_cnt   <= '0;
      load_cnt   <= '0;
      run_len    <= 4'd0;
    end else begin
      state      <= state_n;
      ref_val    <= ref_n;
      last_dir   <= last_dir_n;
      dec_valid  <= dec_valid_n;
      is_up      <= is_up_n;
      is_down    <= is_down_n;
      is_load    <= is_load_n;
      dir_change <= dir_change_n;
      load_value <= load_value_n;
      up_cnt     <= up_cnt_n;
      down_cnt   <= down_cnt_n;
      load_cnt   <= load_cnt_n;
      run_len    <= run_len_n;
    end
  end

endmodule

// File: tb/tb_counter_step_decoder.sv
// Bench for counter_step_decoder: directed samples drive two instances (CNT_W=8
// and CNT_W=2) sharing inputs; monitors pop expected decodes from queues.
module tb_counter_step_decoder;

  typedef struct packed {
    logic       up;
    logic       down;
    logic       load;
    logic       dc;
    logic [3:0] lv;
    logic [7:0] uc;
    logic [7:0] dn;
    logic [7:0] lc;
    logic [3:0] rl;
  } exp_t;

  logic       clk = 1'b0;
  logic       clear = 1'b0;
  logic       sample_valid = 1'b0;
  logic [3:0] sample = 4'd0;
  logic       resync = 1'b0;

  logic       a_dv, a_up, a_down, a_load, a_dc, a_st;
  logic [3:0] a_lv, a_rl;
  logic [7:0] a_uc, a_dn, a_lc;
  logic       b_dv, b_up, b_down, b_load, b_dc, b_st;
  logic [3:0] b_lv, b_rl;
  logic [1:0] b_uc, b_dn, b_lc;

  exp_t exp_a[$];
  exp_t exp_b[$];
  int   checks = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  counter_step_decoder #(.CNT_W(8)) dut_a (
    .clk(clk), .clear(clear), .sample_valid(sample_valid), .sample(sample),
    .resync(resync), .dec_valid(a_dv), .is_up(a_up), .is_down(a_down),
    .is_load(a_load), .load_value(a_lv), .up_cnt(a_uc), .down_cnt(a_dn),
    .load_cnt(a_lc), .run_len(a_rl), .dir_change(a_dc), .fsm_state(a_st)
  );

  counter_step_decoder #(.CNT_W(2)) dut_b (
    .clk(clk), .clear(clear), .sample_valid(sample_valid), .sample(sample),
    .resync(resync), .dec_valid(b_dv), .is_up(b_up), .is_down(b_down),
    .is_load(b_load), .load_value(b_lv), .up_cnt(b_uc), .down_cnt(b_dn),
    .load_cnt(b_lc), .run_len(b_rl), .dir_change(b_dc), .fsm_state(b_st)
  );

  function automatic logic [7:0] sat2(input int v);
    return 8'((v > 3) ? 3 : v);
  endfunction

  // One input cycle; the expected decode is queued on the edge that accepts it.
  task automatic drive(input logic sv, input logic rs, input int s, input bit dv,
                       input bit u, input bit d, input bit l, input bit dc,
                       input int lv, input int uc, input int dn, input int lc,
                       input int rl);
    exp_t e;
    @(negedge clk);
    sample_valid = sv;
    resync       = rs;
    sample       = 4'(s);
    @(posedge clk);
    if (dv) begin
      e = '{up: u, down: d, load: l, dc: dc, lv: 4'(lv), uc: 8'(uc), dn: 8'(dn),
            lc: 8'(lc), rl: 4'(rl)};
      exp_a.push_back(e);
      e.uc = sat2(uc);
      e.dn = sat2(dn);
      e.lc = sat2(lc);
      exp_b.push_back(e);
    end
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 0, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({a_dv, a_up, a_down, a_load, a_dc, a_st, a_lv, a_rl, a_uc, a_dn, a_lc} !== '0) begin
      fails++;
      $display("FAIL %s_a: got dv=%b u=%b d=%b l=%b dc=%b st=%b lv=%0d rl=%0d uc=%0d dn=%0d lc=%0d, required all 0",
               name, a_dv, a_up, a_down, a_load, a_dc, a_st, a_lv, a_rl, a_uc, a_dn, a_lc);
    end
    checks++;
    if ({b_dv, b_up, b_down, b_load, b_dc, b_st, b_lv, b_rl, b_uc, b_dn, b_lc} !== '0) begin
      fails++;
      $display("FAIL %s_b: got dv=%b u=%b d=%b l=%b dc=%b st=%b lv=%0d rl=%0d uc=%0d dn=%0d lc=%0d, required all 0",
               name, b_dv, b_up, b_down, b_load, b_dc, b_st, b_lv, b_rl, b_uc, b_dn, b_lc);
    end
  endtask

  always @(negedge clk) begin
    exp_t act, e;
    act = '{up: a_up, down: a_down, load: a_load, dc: a_dc, lv: a_lv, uc: a_uc,
            dn: a_dn, lc: a_lc, rl: a_rl};
    checks++;
    if (a_dv) begin
      if (exp_a.size() == 0) begin
        fails++;
        $display("FAIL dec_a: unexpected dec_valid, got %h", act);
      end else begin
        e = exp_a.pop_front();
        if (act !== e) begin
          fails++;
          $display("FAIL dec_a: got %h required %h", act, e);
        end
      end
    end else if (exp_a.size() != 0) begin
      e = exp_a.pop_front();
      fails++;
      $display("FAIL dec_a: no dec_valid, required %h", e);
    end else if ({a_up, a_down, a_load, a_dc} !== 4'b0) begin
      fails++;
      $display("FAIL pulse_a: got %b required 0000", {a_up, a_down, a_load, a_dc});
    end
  end

  always @(negedge clk) begin
    exp_t act, e;
    act = '{up: b_up, down: b_down, load: b_load, dc: b_dc, lv: b_lv, uc: 8'(b_uc),
            dn: 8'(b_dn), lc: 8'(b_lc), rl: b_rl};
    checks++;
    if (b_dv) begin
      if (exp_b.size() == 0) begin
        fails++;
        $display("FAIL dec_b: unexpected dec_valid, got %h", act);
      end else begin
        e = exp_b.pop_front();
        if (act !== e) begin
          fails++;
          $display("FAIL dec_b: got %h required %h", act, e);
        end
      end
    end else if (exp_b.size() != 0) begin
      e = exp_b.pop_front();
      fails++;
      $display("FAIL dec_b: no dec_valid, required %h", e);
    end else if ({b_up, b_down, b_load, b_dc} !== 4'b0) begin
      fails++;
      $display("FAIL pulse_b: got %b required 0000", {b_up, b_down, b_load, b_dc});
    end
  end

  initial begin
    #1 clear = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1 check_zero("reset");
    @(negedge clk);
    clear = 1'b0;

    // sv rs  s   dv  u  d  l  dc lv uc dn lc rl
    drive(1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 3,  1, 1, 0, 0, 0, 0, 1, 0, 0, 1);
    drive(1, 0, 6,  1, 1, 0, 0, 0, 0, 2, 0, 0, 2);
    drive(1, 0, 9,  1, 1, 0, 0, 0, 0, 3, 0, 0, 3);
    drive(1, 1, 2,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 13, 1, 0, 1, 0, 1, 0, 3, 1, 0, 1);
    drive(1, 0, 8,  1, 0, 1, 0, 0, 0, 3, 2, 0, 2);
    drive(1, 0, 3,  1, 0, 1, 0, 0, 0, 3, 3, 0, 3);
    drive(1, 1, 14, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 1,  1, 1, 0, 0, 1, 0, 4, 3, 0, 1);
    drive(1, 0, 12, 1, 0, 1, 0, 1, 0, 4, 4, 0, 1);
    drive(1, 0, 15, 1, 1, 0, 0, 1, 0, 5, 4, 0, 1);
    drive(1, 1, 5,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 5,  1, 0, 0, 1, 0, 5, 5, 4, 1, 0);
    drive(1, 0, 9,  1, 0, 0, 1, 0, 9, 5, 4, 2, 0);
    idle();
    drive(0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 9,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 12, 1, 1, 0, 0, 0, 9, 6, 4, 2, 1);
    idle();

    // Asynchronous clear between clock edges.
    @(negedge clk);
    #1 clear = 1'b1;
    #1 check_zero("clear");
    @(negedge clk);
    clear = 1'b0;

    drive(1, 1, 7,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 10, 1, 1, 0, 0, 0, 0, 1, 0, 0, 1);
    for (int k = 2; k <= 17; k++) begin
      drive(1, 0, (10 + 3 * (k - 1)) % 16, 1, 1, 0, 0, 0, 0, k, 0, 0, (k > 15) ? 15 : k);
    end
    idle();
    idle();
    @(negedge clk);
    #1;
    checks++;
    if (exp_a.size() + exp_b.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending decodes, required 0", exp_a.size() + exp_b.size());
    end
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
